// File: rtl/evu_counter_bank.sv
// Performance-event counter bank.
// NUM_CNT counters, each with its own event select, counting mode, enable,
// overflow flag and interrupt enable. Software reaches everything through a
// single-cycle register port.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   event_i            packed per-event increments, event e at [e*INC_W +: INC_W]
//   inhibit_i          global count inhibit (debug mode)
//   cfg_req_i/we_i     register access valid / write strobe
//   cfg_addr_i         register index
//   cfg_wdata_i        write data
//   cfg_rdata_o        read data, combinational from current state
//   irq_o              overflow interrupt, registered
module evu_counter_bank #(
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned INC_W      = 2,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_EVENTS*INC_W-1:0]   event_i,
  input  logic                          inhibit_i,
  input  logic                          cfg_req_i,
  input  logic                          cfg_we_i,
  input  logic [5:0]                    cfg_addr_i,
  input  logic [63:0]                   cfg_wdata_i,
  output logic [63:0]                   cfg_rdata_o,
  output logic                          irq_o
);

  localparam int unsigned SEL_W  = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned SUM_W  = CNT_W + 1;

  // Architectural state
  logic [SEL_W-1:0]   sel_q   [NUM_CNT];
  logic [CNT_W-1:0]   cnt_q   [NUM_CNT];
  logic [NUM_CNT-1:0] en_q, mode_q, irq_en_q, ovf_q;
  logic               freeze_q;
  logic               irq_q;

  // Next-state values
  logic [SEL_W-1:0]   sel_d   [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d   [NUM_CNT];
  logic [NUM_CNT-1:0] en_d, mode_d, irq_en_d, ovf_d, ovf_set, ovf_clr;
  logic               freeze_d;
  logic               irq_d;

  // Per-counter datapath intermediates
  logic [INC_W-1:0]   ev_k    [NUM_CNT];
  logic [INC_W-1:0]   inc_k   [NUM_CNT];
  logic [SUM_W-1:0]   sum_k   [NUM_CNT];
  logic               wr;

  // Increment selection, counter update and register writes
  always_comb begin
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    freeze_d = freeze_q;
    ovf_set  = '0;
    ovf_clr  = '0;
    ev_k     = '{default: '0};
    inc_k    = '{default: '0};
    sum_k    = '{default: '0};
    wr       = cfg_req_i & cfg_we_i;

    if (wr && cfg_addr_i == ADDR_W'(0)) freeze_d = cfg_wdata_i[0];
    if (wr && cfg_addr_i == ADDR_W'(1)) ovf_clr  = cfg_wdata_i[NUM_CNT-1:0];

    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      // Explicit mux so out-of-range selects resolve to zero
      for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
        if (sel_q[k] == SEL_W'(e)) ev_k[k] = event_i[e*INC_W +: INC_W];
      end
      if (en_q[k] && !freeze_q && !inhibit_i && (32'(sel_q[k]) < NUM_EVENTS)) begin
        inc_k[k] = mode_q[k] ? INC_W'(ev_k[k] != '0) : ev_k[k];
      end
      sum_k[k] = {1'b0, cnt_q[k]} + SUM_W'(inc_k[k]);

      // A software write to the counter discards this cycle's increment
      if (wr && cfg_addr_i == ADDR_W'(3 + 2*k)) begin
        cnt_d[k] = cfg_wdata_i[CNT_W-1:0];
      end else begin
        cnt_d[k]   = sum_k[k][CNT_W-1:0];
        ovf_set[k] = sum_k[k][CNT_W];
      end

      if (wr && cfg_addr_i == ADDR_W'(2 + 2*k)) begin
        sel_d[k]    = cfg_wdata_i[7:0];
        en_d[k]     = cfg_wdata_i[8];
        mode_d[k]   = cfg_wdata_i[9];
        irq_en_d[k] = cfg_wdata_i[10];
      end
    end

    // New overflow takes priority over a same-cycle clear
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    irq_d = |(ovf_d & irq_en_d);
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        sel_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      en_q     <= '0;
      mode_q   <= '0;
      irq_en_q <= '0;
      ovf_q    <= '0;
      freeze_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        sel_q[k] <= sel_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      en_q     <= en_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      freeze_q <= freeze_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;

  // Read mux; idle port and unmapped addresses read zero
  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_req_i) begin
      if (cfg_addr_i == ADDR_W'(0)) cfg_rdata_o[0] = freeze_q;
      if (cfg_addr_i == ADDR_W'(1)) cfg_rdata_o[NUM_CNT-1:0] = ovf_q;
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        if (cfg_addr_i == ADDR_W'(2 + 2*k)) begin
          cfg_rdata_o[7:0] = sel_q[k];
          cfg_rdata_o[8]   = en_q[k];
          cfg_rdata_o[9]   = mode_q[k];
          cfg_rdata_o[10]  = irq_en_q[k];
        end
        if (cfg_addr_i == ADDR_W'(3 + 2*k)) cfg_rdata_o[CNT_W-1:0] = cnt_q[k];
      end
    end
  end

endmodule
